// File: rtl/impl_checker.sv
// Per-channel implication checker: an attempt (en & ante) expects cons either exactly
// LAT clocks later (MODE 0) or anywhere within 1..LAT clocks (MODE 1).
module impl_checker #(
    parameter  int N_CH  = 2,
    parameter  int LAT   = 1,
    parameter  int MODE  = 0,
    parameter  int CNT_W = 8,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic [N_CH-1:0]         en,
    input  logic [N_CH-1:0]         ante,
    input  logic [N_CH-1:0]         cons,
    output logic [N_CH-1:0]         pass,
    output logic [N_CH-1:0]         fail,
    output logic [N_CH*CNT_W-1:0]   fail_cnt,
    output logic                    any_fail,
    output logic [CH_W-1:0]         first_fail_ch
);

    logic [LAT-1:0]   age_q [N_CH];
    logic [LAT-1:0]   age_d [N_CH];
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]  pass_q, pass_d;
    logic [N_CH-1:0]  fail_q, fail_d;
    logic             any_q, any_d;
    logic [CH_W-1:0]  ffc_q, ffc_d;

    always_comb begin
        logic [LAT:0] shift;
        logic         start;
        logic         found;
        pass_d = '0;
        fail_d = '0;
        any_d  = any_q;
        ffc_d  = ffc_q;
        found  = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            start    = en[i] & ante[i];
            shift    = {age_q[i], start};
            cnt_d[i] = cnt_q[i];
            if (MODE == 0) begin
                if (age_q[i][LAT-1]) begin
                    pass_d[i] = cons[i];
                    fail_d[i] = ~cons[i];
                end
            end else if (cons[i] && (|age_q[i])) begin
                // One cons satisfies every pending attempt; a same-edge start survives.
                pass_d[i] = 1'b1;
                shift     = {{LAT{1'b0}}, start};
            end else begin
                fail_d[i] = age_q[i][LAT-1];
            end
            age_d[i] = shift[LAT-1:0];
            if (fail_d[i]) begin
                if (cnt_q[i] != '1) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
                if (!any_q && !found) begin
                    ffc_d = CH_W'(i);
                    found = 1'b1;
                end
                any_d = 1'b1;
            end
        end
        if (clr) begin
            pass_d = '0;
            fail_d = '0;
            any_d  = 1'b0;
            ffc_d  = '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                age_d[i] = '0;
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_q <= '0;
            fail_q <= '0;
            any_q  <= 1'b0;
            ffc_q  <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                age_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            pass_q <= pass_d;
            fail_q <= fail_d;
            any_q  <= any_d;
            ffc_q  <= ffc_d;
            for (int unsigned i = 0; i < N_CH; i++) begin
                age_q[i] <= age_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_cnt
        assign fail_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    assign pass          = pass_q;
    assign fail          = fail_q;
    assign any_fail      = any_q;
    assign first_fail_ch = ffc_q;

endmodule

// File: tb/tb_impl_checker.sv
// Directed bench: vector table on a LAT=1/MODE 0 instance, hand sequences on
// LAT=3/MODE 1 and LAT=2/MODE 0 instances sharing the same stimulus.
module tb_impl_checker;

    logic       clk = 1'b0;
    logic       rst, clr;
    logic [1:0] en, ante, cons;

    logic [1:0]  pass_a, fail_a, pass_b, fail_b, pass_c, fail_c;
    logic [3:0]  cnt_a;
    logic [15:0] cnt_b, cnt_c;
    logic        any_a, any_b, any_c;
    logic        ffc_a, ffc_b, ffc_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    impl_checker #(.N_CH(2), .LAT(1), .MODE(0), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .ante(ante), .cons(cons),
        .pass(pass_a), .fail(fail_a), .fail_cnt(cnt_a), .any_fail(any_a),
        .first_fail_ch(ffc_a)
    );

    impl_checker #(.N_CH(2), .LAT(3), .MODE(1), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .ante(ante), .cons(cons),
        .pass(pass_b), .fail(fail_b), .fail_cnt(cnt_b), .any_fail(any_b),
        .first_fail_ch(ffc_b)
    );

    impl_checker #(.N_CH(2), .LAT(2), .MODE(0), .CNT_W(8)) dut_c (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .ante(ante), .cons(cons),
        .pass(pass_c), .fail(fail_c), .fail_cnt(cnt_c), .any_fail(any_c),
        .first_fail_ch(ffc_c)
    );

    typedef struct {
        logic [1:0] en, ante, cons;
        logic       clr;
        logic [1:0] p, f;
        logic [3:0] cnt;
        logic       any;
        logic       ffc;
    } vec_t;

    vec_t tv [26];

    function automatic vec_t v(input logic [1:0] e, a, c, input logic cl,
                               input logic [1:0] p, f, input logic [3:0] cn,
                               input logic an, ff);
        vec_t r;
        r.en = e; r.ante = a; r.cons = c; r.clr = cl;
        r.p = p; r.f = f; r.cnt = cn; r.any = an; r.ffc = ff;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, then sample 1 ns after the rising edge.
    task automatic step(input logic [1:0] e, a, c, input logic cl);
        @(negedge clk);
        en = e; ante = a; cons = c; clr = cl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //        en     ante   cons   clr   pass   fail   cnt{1,0} any ffc
        tv[0]  = v(2'b11, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000, 0, 0);
        tv[1]  = v(2'b00, 2'b00, 2'b01, 1'b0, 2'b01, 2'b00, 4'b0000, 0, 0);
        tv[2]  = v(2'b01, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000, 0, 0);
        tv[3]  = v(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b01, 4'b0001, 1, 0);
        tv[4]  = v(2'b01, 2'b01, 2'b00, 1'b1, 2'b00, 2'b00, 4'b0000, 0, 0);
        tv[5]  = v(2'b01, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000, 0, 0);
        tv[6]  = v(2'b01, 2'b01, 2'b00, 1'b0, 2'b00, 2'b01, 4'b0001, 1, 0);
        tv[7]  = v(2'b01, 2'b01, 2'b00, 1'b0, 2'b00, 2'b01, 4'b0010, 1, 0);
        tv[8]  = v(2'b01, 2'b01, 2'b00, 1'b0, 2'b00, 2'b01, 4'b0011, 1, 0);
        tv[9]  = v(2'b01, 2'b01, 2'b00, 1'b0, 2'b00, 2'b01, 4'b0011, 1, 0);
        tv[10] = v(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b01, 4'b0011, 1, 0);
        tv[11] = v(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0011, 1, 0);
        tv[12] = v(2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 4'b0000, 0, 0);
        tv[13] = v(2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000, 0, 0);
        tv[14] = v(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b11, 4'b0101, 1, 0);
        tv[15] = v(2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 4'b0000, 0, 0);
        tv[16] = v(2'b10, 2'b10, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000, 0, 0);
        tv[17] = v(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b10, 4'b0100, 1, 1);
        tv[18] = v(2'b11, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0100, 1, 1);
        tv[19] = v(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b01, 4'b0101, 1, 1);
        tv[20] = v(2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 4'b0000, 0, 0);
        tv[21] = v(2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000, 0, 0);
        tv[22] = v(2'b00, 2'b00, 2'b01, 1'b0, 2'b01, 2'b10, 4'b0100, 1, 1);
        tv[23] = v(2'b01, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0100, 1, 1);
        tv[24] = v(2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 4'b0000, 0, 0);
        tv[25] = v(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000, 0, 0);

        rst = 1'b1; clr = 1'b0; en = '0; ante = '0; cons = '0;
        #1;
        chk("reset_pf", {pass_a, fail_a}, 4'b0000);
        chk("reset_cnt", cnt_a, 4'b0000);
        chk("reset_any_ffc", {any_a, ffc_a}, 2'b00);
        #1 rst = 1'b0;

        for (int i = 0; i < 26; i++) begin
            step(tv[i].en, tv[i].ante, tv[i].cons, tv[i].clr);
            chk($sformatf("a_pass_r%0d", i), pass_a, tv[i].p);
            chk($sformatf("a_fail_r%0d", i), fail_a, tv[i].f);
            chk($sformatf("a_cnt_r%0d", i), cnt_a, tv[i].cnt);
            chk($sformatf("a_any_r%0d", i), any_a, tv[i].any);
            chk($sformatf("a_ffc_r%0d", i), ffc_a, tv[i].ffc);
        end

        // MODE 1, LAT 3: two overlapping attempts satisfied by one cons
        step(2'b00, 2'b00, 2'b00, 1'b1);
        step(2'b11, 2'b10, 2'b00, 1'b0); chk("b1_e0", {pass_b, fail_b}, 4'b0000);
        step(2'b11, 2'b10, 2'b00, 1'b0); chk("b1_e1", {pass_b, fail_b}, 4'b0000);
        step(2'b11, 2'b00, 2'b00, 1'b0); chk("b1_e2", {pass_b, fail_b}, 4'b0000);
        step(2'b11, 2'b00, 2'b10, 1'b0); chk("b1_e3", {pass_b, fail_b}, 4'b1000);
        step(2'b11, 2'b00, 2'b00, 1'b0); chk("b1_e4", {pass_b, fail_b}, 4'b0000);
        step(2'b11, 2'b00, 2'b00, 1'b0); chk("b1_e5", {pass_b, fail_b}, 4'b0000);
        chk("b1_cnt", cnt_b, 16'h0000);

        // MODE 1: same attempts with cons never high fail one per edge
        step(2'b11, 2'b10, 2'b00, 1'b0); chk("b2_e0", {pass_b, fail_b}, 4'b0000);
        step(2'b11, 2'b10, 2'b00, 1'b0); chk("b2_e1", {pass_b, fail_b}, 4'b0000);
        step(2'b11, 2'b00, 2'b00, 1'b0); chk("b2_e2", {pass_b, fail_b}, 4'b0000);
        step(2'b11, 2'b00, 2'b00, 1'b0); chk("b2_e3", {pass_b, fail_b}, 4'b0010);
        step(2'b11, 2'b00, 2'b00, 1'b0); chk("b2_e4", {pass_b, fail_b}, 4'b0010);
        step(2'b11, 2'b00, 2'b00, 1'b0); chk("b2_e5", {pass_b, fail_b}, 4'b0000);
        chk("b2_cnt", cnt_b, 16'h0200);
        chk("b2_any_ffc", {any_b, ffc_b}, 2'b11);

        // MODE 1: same-edge cons does not satisfy; age-1 cons does
        step(2'b11, 2'b10, 2'b10, 1'b0); chk("b3_e0", {pass_b, fail_b}, 4'b0000);
        step(2'b11, 2'b00, 2'b00, 1'b0); chk("b3_e1", {pass_b, fail_b}, 4'b0000);
        step(2'b11, 2'b00, 2'b00, 1'b0); chk("b3_e2", {pass_b, fail_b}, 4'b0000);
        step(2'b11, 2'b00, 2'b00, 1'b0); chk("b3_e3", {pass_b, fail_b}, 4'b0010);
        step(2'b11, 2'b01, 2'b00, 1'b0); chk("b3_e4", {pass_b, fail_b}, 4'b0000);
        step(2'b11, 2'b00, 2'b01, 1'b0); chk("b3_e5", {pass_b, fail_b}, 4'b0100);
        chk("b3_cnt", cnt_b, 16'h0300);

        // MODE 0, LAT 2: evaluation only at exactly two edges
        step(2'b00, 2'b00, 2'b00, 1'b1);
        step(2'b01, 2'b01, 2'b00, 1'b0); chk("c_e0", {pass_c, fail_c}, 4'b0000);
        step(2'b01, 2'b00, 2'b01, 1'b0); chk("c_e1", {pass_c, fail_c}, 4'b0000);
        step(2'b01, 2'b00, 2'b00, 1'b0); chk("c_e2", {pass_c, fail_c}, 4'b0001);
        chk("c_cnt", cnt_c, 16'h0001);
        chk("c_any", any_c, 1'b1);

        // Attempt in flight, then asynchronous reset pulse mid-cycle
        step(2'b01, 2'b01, 2'b00, 1'b0); chk("c_e3", {pass_c, fail_c}, 4'b0000);
        step(2'b01, 2'b00, 2'b00, 1'b0); chk("c_e4", {pass_c, fail_c}, 4'b0000);
        @(negedge clk);
        rst = 1'b1; en = 2'b01; ante = 2'b01; cons = 2'b01;
        #1;
        chk("c_rst_pf", {pass_c, fail_c}, 4'b0000);
        chk("c_rst_cnt", cnt_c, 16'h0000);
        chk("c_rst_any_ffc", {any_c, ffc_c}, 2'b00);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("c_e5", {pass_c, fail_c}, 4'b0000);
        step(2'b01, 2'b00, 2'b01, 1'b0); chk("c_e6", {pass_c, fail_c}, 4'b0000);
        step(2'b01, 2'b00, 2'b01, 1'b0); chk("c_e7", {pass_c, fail_c}, 4'b0100);

        // en low gates the attempt entirely
        step(2'b00, 2'b11, 2'b00, 1'b0); chk("c_e8", {pass_c, fail_c}, 4'b0000);
        step(2'b00, 2'b00, 2'b00, 1'b0); chk("c_e9", {pass_c, fail_c}, 4'b0000);
        step(2'b00, 2'b00, 2'b00, 1'b0); chk("c_e10", {pass_c, fail_c}, 4'b0000);
        chk("c_final_cnt", cnt_c, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
